mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester round-robin arbiter that shares one single-port, one-cycle-read-latency word memory (byte write strobes, registered read data) between two masters speaking the PicoRV32 native memory handshake. Sits between the CPU core plus a second master (loader/debug or checker port) and the memory in `design_top`. Makes every access take a fixed three-state sequence, so neither master needs to know the memory's read latency.

## Interface
Parameters:
- `ADDR_W`, 5: memory word-index width. Memory depth is 2^ADDR_W words.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `p0_valid` / `p1_valid`  in  1  request from port 0 / port 1
- `p0_addr` / `p1_addr`  in  32  byte address; bits [1:0] ignored
- `p0_wdata` / `p1_wdata`  in  32  write data
- `p0_wstrb` / `p1_wstrb`  in  4  byte write strobes; 0 means read
- `p0_ready` / `p1_ready`  out  1  one-cycle completion pulse
- `p0_rdata` / `p1_rdata`  out  32  read data, valid only while the matching ready is high
- `mem_wen`  out  4  byte write enables to memory
- `mem_addr`  out  ADDR_W  word index to memory
- `mem_wdata`  out  32  write data to memory
- `mem_rdata`  in  32  registered read data from memory (one cycle after `mem_addr`)
- `busy`  out  1  high in any state other than IDLE
- `grant`  out  1  index of the port owning the current or most recent access

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any valid is high, latch the winner into `grant`, decode out-of-range, and go to ACCESS.
  - If no valid is high, stay in IDLE.
- Arbitration is round-robin on the `last` register:
  - Both valid: the port ≠ `last` wins.
  - One valid: that port wins.
  - `last` updates to the winner on the IDLE→ACCESS transition.
- ACCESS:
  - `mem_addr` = winner `addr[ADDR_W+1:2]`.
  - `mem_wdata` = winner wdata.
  - `mem_wen` = winner wstrb, forced to 0 if out-of-range.
  - Always go to RESP.
- RESP:
  - Pulse the winner's ready.
  - Winner's rdata = `mem_rdata`, or 0 if out-of-range.
  - Always go to IDLE.
- Out-of-range means `addr[31:ADDR_W+2]` ≠ 0. Such a write is dropped; such a read returns 0. The access still completes normally.
- The master must hold addr/wdata/wstrb stable from valid until ready. The arbiter samples them in ACCESS.
- If the winner drops valid during ACCESS or RESP, the access still completes: a write is committed and ready still pulses.
- The losing port's valid stays pending and is served in the next IDLE.
- Outside RESP: both ready = 0 and both rdata = 0. Outside ACCESS: `mem_wen` = 0, `mem_addr` = 0, `mem_wdata` = 0.

## Timing
- Reset values:
  - state = IDLE, `last` = 1 (port 0 wins the first contention), `grant` = 0.
  - `p0_ready` = `p1_ready` = 0, `busy` = 0, all mem outputs 0, rdata outputs 0.
- Latency: valid seen in IDLE at cycle t → ACCESS at t+1 → ready at t+2 → IDLE at t+3.
  - Peak throughput is one access per 3 cycles.
  - Under continuous contention, grants alternate 0,1,0,1.
- Memory write commits at the rising edge that ends ACCESS. A read in a later ACCESS returns the new data.
- The arbiter starts no new request in RESP, even if valid is high. This prevents re-serving a request whose valid has not yet dropped after ready.
- Reset mid-access: state goes to IDLE at the next edge and no ready is issued.
  - A write whose ACCESS cycle coincides with reset is suppressed (`mem_wen` forced 0 when `reset` = 1).
  - Memory contents are unaffected by reset.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/ACCESS/RESP), port-count constant 2, default `ADDR_W`.
- Sub-module `rr_grant2`: combinational two-way round-robin pick from {`valid0`, `valid1`, `last`} → {`any`, `winner`}. The `last` register stays in the top.
- Top holds the FSM, the `grant`/`last`/out-of-range registers, and the output muxing.

## Test plan
- Port 0 writes `addr` 0x08 = 0xDEADBEEF (wstrb 0xF), then reads 0x08 → `p0_ready` 2 cycles after each valid; read returns 0xDEADBEEF; `mem_wen` = 0xF for exactly one cycle.
- Port 0 and port 1 both valid out of reset → port 0 granted first, port 1 ready 3 cycles later. Hold both valid for 4 accesses → grants 0,1,0,1.
- Byte-strobe write: word 3 preloaded to 0x11223344, port 1 writes 0xAABBCCDD with wstrb 0x2 → readback 0x1122CC44.
- Port 0 writes `addr` 0x80 (out of range for `ADDR_W` 5) → ready still pulses; `mem_wen` stays 0; word 0 unchanged. A read of 0x80 returns 0.
- Assert `reset` in the ACCESS cycle of a port 1 write → no `p1_ready`; target word unchanged; `busy` = 0 after the reset edge; next request from port 0 wins.
- Port 0 drops valid during ACCESS → ready still pulses and the write is committed. No spurious second access follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    localparam int NUM_PORTS      = 2;
    localparam int DEFAULT_ADDR_W = 5;

    // True when any byte-address bit above the word index is set.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int unsigned aw);
        return (addr >> (aw + 32'd2)) != 32'd0;
    endfunction

endpackage

// File: rtl/rr_grant2.sv
// Combinational two-way round-robin pick: the port that did not win last time wins a tie.
module rr_grant2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last,
    output logic any,
    output logic winner
);

    always_comb begin
        any    = valid0 | valid1;
        winner = (valid0 && valid1) ? ~last : valid1;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port, registered-read memory between two
// PicoRV32-style masters; every access runs IDLE -> ACCESS -> RESP.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              p0_valid,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    input  logic [3:0]        p0_wstrb,
    output logic              p0_ready,
    output logic [31:0]       p0_rdata,
    input  logic              p1_valid,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    input  logic [3:0]        p1_wstrb,
    output logic              p1_ready,
    output logic [31:0]       p1_rdata,
    output logic [3:0]        mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    output logic              busy,
    output logic              grant
);

    arb_state_e           state_q, state_d;
    logic                 last_q;
    logic                 grant_q;
    logic                 oor_q;
    logic                 any_req;
    logic                 winner;
    logic [31:0]          win_addr;
    logic [31:0]          sel_addr;
    logic [31:0]          sel_wdata;
    logic [3:0]           sel_wstrb;
    logic [NUM_PORTS-1:0] ready_vec;

    rr_grant2 u_pick (
        .valid0 (p0_valid),
        .valid1 (p1_valid),
        .last   (last_q),
        .any    (any_req),
        .winner (winner)
    );

    // Winner address is decoded in IDLE; the granted port's bus is sampled in ACCESS.
    assign win_addr  = winner  ? p1_addr  : p0_addr;
    assign sel_addr  = grant_q ? p1_addr  : p0_addr;
    assign sel_wdata = grant_q ? p1_wdata : p0_wdata;
    assign sel_wstrb = grant_q ? p1_wstrb : p0_wstrb;

    wire unused_sel_addr = ^{sel_addr[1:0], sel_addr[31:ADDR_W+2]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            grant_q <= 1'b0;
            oor_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && any_req) begin
                grant_q <= winner;
                last_q  <= winner;
                oor_q   <= addr_out_of_range(win_addr, ADDR_W);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        mem_wen   = 4'b0;
        mem_addr  = '0;
        mem_wdata = 32'b0;
        ready_vec = '0;
        p0_rdata  = 32'b0;
        p1_rdata  = 32'b0;
        case (state_q)
            IDLE: begin
                if (any_req) state_d = ACCESS;
            end
            ACCESS: begin
                mem_addr  = sel_addr[ADDR_W+1:2];
                mem_wdata = sel_wdata;
                // A write landing on a reset edge must not corrupt memory.
                mem_wen   = (oor_q || reset) ? 4'b0 : sel_wstrb;
                state_d   = RESP;
            end
            RESP: begin
                ready_vec[grant_q] = 1'b1;
                if (grant_q) p1_rdata = oor_q ? 32'b0 : mem_rdata;
                else         p0_rdata = oor_q ? 32'b0 : mem_rdata;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign p0_ready = ready_vec[0];
    assign p1_ready = ready_vec[1];
    assign busy     = (state_q != IDLE);
    assign grant    = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural registered-read memory.
module tb_mem_port_arbiter;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_valid, p1_valid;
    logic [31:0]   p0_addr, p1_addr, p0_wdata, p1_wdata;
    logic [3:0]    p0_wstrb, p1_wstrb;
    logic          p0_ready, p1_ready;
    logic [31:0]   p0_rdata, p1_rdata;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic          busy, grant;

    int checks = 0;
    int errors = 0;
    int wen_cycles = 0;
    logic [3:0] last_wen = 4'h0;

    typedef struct {
        int          port;
        bit          chk;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .p0_valid(p0_valid), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_wstrb(p0_wstrb),
        .p0_ready(p0_ready), .p0_rdata(p0_rdata),
        .p1_valid(p1_valid), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_wstrb(p1_wstrb),
        .p1_ready(p1_ready), .p1_rdata(p1_rdata),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .grant(grant)
    );

    // Memory model: byte-strobed write, one-cycle registered read, plus a preload port.
    logic [31:0] mem [0:31];
    logic        pre_en = 1'b0;
    logic [4:0]  pre_addr = 5'd0;
    logic [31:0] pre_data = 32'd0;

    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        for (int b = 0; b < 4; b++)
            if (mem_wen[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        mem_rdata <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (mem_wen != 4'h0) begin
            wen_cycles++;
            last_wen = mem_wen;
        end
    end

    // Completion monitor: every ready pulse must match the oldest expected entry.
    always @(negedge clk) begin
        if (p0_ready || p1_ready) begin
            checks++;
            if (p0_ready && p1_ready) begin
                errors++;
                $display("FAIL ready_both: p0_ready=%0b p1_ready=%0b, required one-hot", p0_ready, p1_ready);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL spurious_ready: port %0d ready with no outstanding request", p1_ready ? 1 : 0);
            end else begin
                mon_e = sb.pop_front();
                if ((p1_ready ? 1 : 0) != mon_e.port || grant !== mon_e.port[0]) begin
                    errors++;
                    $display("FAIL ready_port: got port %0d grant %0b, required port %0d",
                             p1_ready ? 1 : 0, grant, mon_e.port);
                end else if (mon_e.chk) begin
                    if ((p1_ready ? p1_rdata : p0_rdata) !== mon_e.data) begin
                        errors++;
                        $display("FAIL rdata_p%0d: got %08h, required %08h", mon_e.port,
                                 p1_ready ? p1_rdata : p0_rdata, mon_e.data);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input int a, input logic [31:0] d);
        pre_addr = a[4:0];
        pre_data = d;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    task automatic drive(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
        if (port == 0) begin
            p0_addr = addr; p0_wdata = wdata; p0_wstrb = wstrb; p0_valid = 1'b1;
        end else begin
            p1_addr = addr; p1_wdata = wdata; p1_wstrb = wstrb; p1_valid = 1'b1;
        end
    endtask

    task automatic wait_ready(input int port, output int cyc);
        cyc = -1;
        for (int k = 1; k <= 12 && cyc < 0; k++) begin
            @(negedge clk);
            if ((port == 0 && p0_ready) || (port == 1 && p1_ready)) cyc = k;
        end
    endtask

    // Issue one access from IDLE, wait for completion, release valid and return to IDLE.
    task automatic do_access(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [3:0] wstrb, input bit chk, input logic [31:0] exp_data,
                             output int cyc);
        sb.push_back('{port, chk, exp_data});
        drive(port, addr, wdata, wstrb);
        wait_ready(port, cyc);
        if (port == 0) p0_valid = 1'b0; else p1_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        p0_valid = 1'b1; p0_addr = 32'h4; p0_wdata = 32'h1; p0_wstrb = 4'hF;
        p1_valid = 1'b1; p1_addr = 32'h8; p1_wdata = 32'h2; p1_wstrb = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b, required 0", busy); end
        checks++;
        if (grant !== 1'b0) begin errors++; $display("FAIL reset_grant: got %0b, required 0", grant); end
        checks++;
        if ({p0_ready, p1_ready} !== 2'b00) begin
            errors++; $display("FAIL reset_ready: got %02b, required 00", {p0_ready, p1_ready});
        end
        checks++;
        if (mem_wen !== 4'h0 || mem_addr !== '0 || mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem_out: wen %0h addr %0h wdata %08h, required all 0", mem_wen, mem_addr, mem_wdata);
        end
        checks++;
        if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %08h/%08h, required 0/0", p0_rdata, p1_rdata);
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        int cyc;
        wen_cycles = 0;
        do_access(0, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL wr_latency: got %0d cycles, required 2", cyc); end
        checks++;
        if (wen_cycles != 1 || last_wen !== 4'hF) begin
            errors++; $display("FAIL wr_wen: got %0d cycles of %0h, required 1 cycle of f", wen_cycles, last_wen);
        end
        do_access(0, 32'h08, 32'h0, 4'h0, 1'b1, 32'hDEADBEEF, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL rd_latency: got %0d cycles, required 2", cyc); end
    endtask

    task automatic test_contention;
        int times[4];
        int ports[4];
        int n = 0;
        preload(2, 32'h22222222);
        preload(5, 32'h55555555);
        apply_reset(2);
        for (int i = 0; i < 4; i++)
            sb.push_back('{i % 2, 1'b1, (i % 2 == 0) ? 32'h22222222 : 32'h55555555});
        drive(0, 32'h08, 32'h0, 4'h0);
        drive(1, 32'h14, 32'h0, 4'h0);
        for (int k = 1; k <= 20 && n < 4; k++) begin
            @(negedge clk);
            if (p0_ready || p1_ready) begin
                times[n] = k;
                ports[n] = p1_ready ? 1 : 0;
                n++;
            end
        end
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (n != 4) begin
            errors++; $display("FAIL rr_count: got %0d completions, required 4", n);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (ports[i] != i % 2 || times[i] != 2 + 3 * i) begin
                    errors++;
                    $display("FAIL rr_seq%0d: got port %0d at cycle %0d, required port %0d at cycle %0d",
                             i, ports[i], times[i], i % 2, 2 + 3 * i);
                end
            end
        end
        while (sb.size() > 4) void'(sb.pop_back());
    endtask

    task automatic test_byte_strobe;
        int cyc;
        preload(3, 32'h11223344);
        do_access(1, 32'h0C, 32'hAABBCCDD, 4'h2, 1'b0, 32'h0, cyc);
        checks++;
        if (mem[3] !== 32'h1122CC44) begin
            errors++; $display("FAIL strobe_mem: got %08h, required 1122cc44", mem[3]);
        end
        do_access(1, 32'h0C, 32'h0, 4'h0, 1'b1, 32'h1122CC44, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL strobe_latency: got %0d cycles, required 2", cyc); end
    endtask

    task automatic test_out_of_range;
        int cyc;
        preload(0, 32'h0BADF00D);
        wen_cycles = 0;
        do_access(0, 32'h80, 32'h12345678, 4'hF, 1'b0, 32'h0, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL oor_wr_latency: got %0d cycles, required 2", cyc); end
        checks++;
        if (wen_cycles != 0) begin
            errors++; $display("FAIL oor_wen: got %0d write cycles, required 0", wen_cycles);
        end
        checks++;
        if (mem[0] !== 32'h0BADF00D) begin
            errors++; $display("FAIL oor_mem: got %08h, required 0badf00d", mem[0]);
        end
        do_access(0, 32'h80, 32'h0, 4'h0, 1'b1, 32'h0, cyc);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL oor_rd_latency: got %0d cycles, required 2", cyc); end
    endtask

    task automatic test_reset_mid;
        int cyc;
        preload(7, 32'h77777777);
        wen_cycles = 0;
        drive(1, 32'h1C, 32'hFFFFFFFF, 4'hF);
        @(posedge clk);
        #1;
        reset = 1'b1;
        p1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1 || mem_wen !== 4'h0) begin
            errors++; $display("FAIL rstmid_access: busy %0b wen %0h, required busy 1 wen 0", busy, mem_wen);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %0b, required 0", busy); end
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (mem[7] !== 32'h77777777 || wen_cycles != 0) begin
            errors++; $display("FAIL rstmid_mem: got %08h after %0d writes, required 77777777", mem[7], wen_cycles);
        end
        sb.push_back('{0, 1'b1, 32'h77777777});
        drive(0, 32'h1C, 32'h0, 4'h0);
        drive(1, 32'h0C, 32'h0, 4'h0);
        wait_ready(0, cyc);
        p0_valid = 1'b0;
        p1_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (cyc != 2) begin errors++; $display("FAIL rstmid_next: p0 ready after %0d cycles, required 2", cyc); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_drop_valid;
        int cyc;
        int busy_cycles = 0;
        preload(9, 32'h0);
        wen_cycles = 0;
        sb.push_back('{0, 1'b0, 32'h0});
        drive(0, 32'h24, 32'hCAFE0009, 4'hF);
        @(negedge clk);
        p0_valid = 1'b0;
        wait_ready(0, cyc);
        checks++;
        if (cyc != 1) begin errors++; $display("FAIL drop_ready: got %0d cycles after drop, required 1", cyc); end
        repeat (4) begin
            @(negedge clk);
            if (busy) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 0) begin
            errors++; $display("FAIL drop_second: busy for %0d cycles, required 0", busy_cycles);
        end
        checks++;
        if (mem[9] !== 32'hCAFE0009 || wen_cycles != 1) begin
            errors++; $display("FAIL drop_mem: got %08h after %0d writes, required cafe0009 after 1", mem[9], wen_cycles);
        end
    endtask

    initial begin
        reset = 1'b1;
        p0_valid = 1'b0; p0_addr = 32'h0; p0_wdata = 32'h0; p0_wstrb = 4'h0;
        p1_valid = 1'b0; p1_addr = 32'h0; p1_wdata = 32'h0; p1_wstrb = 4'h0;
        test_reset;
        test_write_read;
        test_contention;
        test_byte_strobe;
        test_out_of_range;
        test_reset_mid;
        test_drop_valid;
        checks++;
        if (sb.size() != 0) begin
            errors++; $display("FAIL sb_drain: %0d expected completions never seen, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
